// File: rtl/hx8352_delay_us_timer.sv
// Microsecond delay timer for the HX8352 init sequencer: a rising edge on step
// loads delay_us and done is raised after max(delay_us,1) prescaled ticks.
module hx8352_delay_us_timer #(
    parameter int WIDTH      = 16,
    parameter int CLK_PER_US = 1
) (
    input  logic             clk_1MHz,
    input  logic             rst,
    input  logic             step,
    input  logic [WIDTH-1:0] delay_us,
    output logic             done
);

    localparam int               PRE_W      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(CLK_PER_US - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic             step_d_reg;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [PRE_W-1:0] pre_reg, pre_next;
    logic             done_reg, done_next;
    logic             start;
    logic             tick;

    assign start = step & ~step_d_reg;
    assign tick  = (pre_reg == '0);
    assign done  = done_reg;

    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            step_d_reg <= 1'b0;
            cnt_reg    <= '0;
            pre_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            step_d_reg <= step;
            cnt_reg    <= cnt_next;
            pre_reg    <= pre_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pre_next   = pre_reg;
        done_next  = done_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cnt_next   = delay_us;
                    pre_next   = PRE_RELOAD;
                    done_next  = 1'b0;
                    state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                // start edges are deliberately ignored while a delay is running
                if (tick) begin
                    pre_next = PRE_RELOAD;
                    if (cnt_reg <= WIDTH'(1)) begin
                        done_next  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        cnt_next = cnt_reg - WIDTH'(1);
                    end
                end else begin
                    pre_next = pre_reg - PRE_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                done_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hx8352_delay_us_timer.sv
// Bench for hx8352_delay_us_timer: two instances (1 and 3 clocks per us) checked
// every cycle against a due-time model of the start/done handshake.
`timescale 1ns/1ps
module tb_hx8352_delay_us_timer;

    localparam int WIDTH = 16;
    localparam int P_A   = 1;
    localparam int P_B   = 3;

    logic             clk_1MHz;
    logic             rst;
    logic             step;
    logic [WIDTH-1:0] delay_us;
    logic             done_a;
    logic             done_b;

    int     checks;
    int     errors;
    longint cyc;

    bit     m_step_d;
    bit     m_busy [2];
    bit     m_done [2];
    longint m_due  [2];

    hx8352_delay_us_timer #(.WIDTH(WIDTH), .CLK_PER_US(P_A)) u_dut_a (
        .clk_1MHz (clk_1MHz),
        .rst      (rst),
        .step     (step),
        .delay_us (delay_us),
        .done     (done_a)
    );

    hx8352_delay_us_timer #(.WIDTH(WIDTH), .CLK_PER_US(P_B)) u_dut_b (
        .clk_1MHz (clk_1MHz),
        .rst      (rst),
        .step     (step),
        .delay_us (delay_us),
        .done     (done_b)
    );

    initial begin
        clk_1MHz = 1'b0;
        forever #500 clk_1MHz = ~clk_1MHz;
    end

    function automatic longint p_of(int k);
        return (k == 0) ? longint'(P_A) : longint'(P_B);
    endfunction

    task automatic model_clear();
        m_step_d = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b0;
            m_due[k]  = 0;
        end
    endtask

    // Reference: a start edge schedules done at start_cycle + max(d,1)*P,
    // unless that instance is already busy, in which case the edge is ignored.
    task automatic model_edge(input logic s, input logic [WIDTH-1:0] d);
        bit     st;
        longint n;
        if (rst) begin
            model_clear();
            return;
        end
        st       = s && !m_step_d;
        m_step_d = s;
        n        = (d == 0) ? 1 : longint'(d);
        for (int k = 0; k < 2; k++) begin
            if (m_busy[k]) begin
                if (cyc == m_due[k]) begin
                    m_busy[k] = 1'b0;
                    m_done[k] = 1'b1;
                end
            end else if (st) begin
                m_done[k] = 1'b0;
                m_busy[k] = 1'b1;
                m_due[k]  = cyc + n * p_of(k);
            end
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle();
        logic             s;
        logic [WIDTH-1:0] d;
        @(posedge clk_1MHz);
        s = step;
        d = delay_us;
        cyc++;
        model_edge(s, d);
        #1;
        check("done_a", done_a, m_done[0]);
        check("done_b", done_b, m_done[1]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_idle(input int limit);
        int i;
        i = 0;
        while ((m_busy[0] || m_busy[1]) && i < limit) begin
            cycle();
            i++;
        end
    endtask

    // Leaves the bench positioned just after the start edge, step held high.
    task automatic start_delay(input int d);
        step = 1'b0;
        cycle();
        step     = 1'b1;
        delay_us = WIDTH'(d);
        cycle();
    endtask

    task automatic async_reset_pulse_begin();
        #200;
        rst = 1'b1;
        model_clear();
        #1;
        check("rst_async_a", done_a, 1'b0);
        check("rst_async_b", done_b, 1'b0);
    endtask

    initial begin
        int d, hi, gap;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        model_clear();
        rst      = 1'b1;
        step     = 1'b0;
        delay_us = WIDTH'(10000);

        // reset held, then released with step low
        #1;
        check("reset_a", done_a, 1'b0);
        check("reset_b", done_b, 1'b0);
        run(10);
        rst = 1'b0;
        run(5);
        $display("txn reset: done stays low, cyc=%0d", cyc);

        // nominal 10000 us delay, step rises at cycle 30 and is held 30 cycles
        while (cyc < 29) cycle();
        step = 1'b1;
        run(30);
        step = 1'b0;
        wait_idle(40000);
        run(5);
        check("nominal_a", done_a, 1'b1);
        check("nominal_b", done_b, 1'b1);
        $display("txn nominal: delay_us=10000 cyc=%0d", cyc);

        // minimum delays: 0 and 1 both complete one tick after the start edge
        start_delay(0);
        cycle();
        check("min0_a", done_a, 1'b1);
        wait_idle(20);
        $display("txn min: delay_us=0 cyc=%0d", cyc);
        start_delay(1);
        cycle();
        check("min1_a", done_a, 1'b1);
        wait_idle(20);
        $display("txn min: delay_us=1 cyc=%0d", cyc);

        // second start edge mid-count with a new delay_us must be ignored
        start_delay(100);
        run(48);
        step = 1'b0;
        cycle();
        step     = 1'b1;
        delay_us = WIDTH'(5);
        cycle();
        run(49);
        check("ignored_early_a", done_a, 1'b0);
        cycle();
        check("ignored_ontime_a", done_a, 1'b1);
        step = 1'b0;
        wait_idle(400);
        $display("txn ignored restart: delay_us=100 cyc=%0d", cyc);

        // restart directly from DONE
        start_delay(20);
        wait_idle(100);
        run(2);
        check("restart_pre_a", done_a, 1'b1);
        start_delay(7);
        check("restart_drop_a", done_a, 1'b0);
        run(6);
        check("restart_early_a", done_a, 1'b0);
        cycle();
        check("restart_rise_a", done_a, 1'b1);
        wait_idle(40);
        $display("txn restart from done: delay_us=7 cyc=%0d", cyc);

        // asynchronous reset mid-count aborts the delay for good
        start_delay(1000);
        run(399);
        async_reset_pulse_begin();
        run(3);
        step = 1'b0;
        rst  = 1'b0;
        run(1200);
        check("abort_a", done_a, 1'b0);
        check("abort_b", done_b, 1'b0);
        $display("txn reset mid-count: delay_us=1000 cyc=%0d", cyc);

        // step already high at reset release counts as a start edge
        rst = 1'b1;
        model_clear();
        run(2);
        step     = 1'b1;
        delay_us = WIDTH'(3);
        rst      = 1'b0;
        cycle();
        run(2);
        check("release_early_a", done_a, 1'b0);
        cycle();
        check("release_rise_a", done_a, 1'b1);
        wait_idle(20);
        $display("txn release with step high: delay_us=3 cyc=%0d", cyc);

        // randomized handshakes, including stray edges and delay_us churn
        for (int t = 0; t < 25; t++) begin
            d   = $urandom_range(0, 40);
            hi  = $urandom_range(1, 20);
            gap = $urandom_range(0, 150);
            step = 1'b0;
            run($urandom_range(1, 3));
            step     = 1'b1;
            delay_us = WIDTH'(d);
            for (int i = 0; i < hi; i++) begin
                cycle();
                delay_us = WIDTH'($urandom_range(0, 60));
            end
            step = 1'b0;
            for (int i = 0; i < gap; i++) begin
                if ($urandom_range(0, 15) == 0) step = ~step;
                cycle();
            end
            $display("txn random %0d: delay_us=%0d hi=%0d gap=%0d cyc=%0d", t, d, hi, gap, cyc);
        end
        step = 1'b0;
        wait_idle(400);
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
